// File: rtl/multi_capture_pkg.sv
// Shared types and helpers for the multi-channel ADC capture block.
package multi_capture_pkg;

    localparam int CH_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2
    } cap_state_t;

    // First enabled channel strictly after cur, wrapping modulo num_ch.
    // Returns cur when it is the only enabled channel (or none are).
    function automatic logic [CH_SEL_W-1:0] next_enabled(
        input logic [15:0]         mask,
        input logic [CH_SEL_W-1:0] cur,
        input int                  num_ch
    );
        logic [CH_SEL_W-1:0] res;
        logic [CH_SEL_W-1:0] idx;
        res = cur;
        for (int k = 16; k >= 1; k--) begin
            if (k <= num_ch) begin
                idx = CH_SEL_W'((int'(cur) + k) % num_ch);
                if (mask[idx]) res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_capture_pwm.sv
// Shared free-running counter driving one registered PWM comparator per channel.
// Latency: 1 cycle from value change to pwm; no backpressure (free-running).
// Duty = value / 2^SAMPLE_W; no period alignment on value change.
module multi_capture_pwm #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]    values,
    output logic [NUM_CH-1:0]                  pwm
);

    logic [SAMPLE_W-1:0] ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr <= '0;
            pwm <= '0;
        end else begin
            ctr <= ctr + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm[i] <= (ctr < values[i]);
            end
        end
    end

endmodule

// File: rtl/multi_input_capture.sv
// Round-robin ADC capture over an enable mask with per-channel storage, PWM and readback.
// Latency: store 1 cycle after accepted strobe, rd_data 1 cycle; no backpressure, strobes outside WAIT dropped.
// Optional MULTI_CAPTURE_FILTER_EN: stored value follows a first-order IIR instead of the raw sample.
module multi_input_capture
    import multi_capture_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SAMPLE_W    = 10,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int FILT_SHIFT  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_en,
    output logic [CH_SEL_W-1:0]   channel,
    input  logic                  new_sample,
    input  logic [SAMPLE_W-1:0]   sample,
    input  logic [CH_SEL_W-1:0]   sample_channel,
    output logic [NUM_CH-1:0]     pwm,
    output logic [NUM_CH-1:0]     ch_valid,
    output logic                  timeout,
    input  logic [CH_SEL_W-1:0]   rd_sel,
    output logic [SAMPLE_W-1:0]   rd_data
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end
    if (FILT_SHIFT < 1 || FILT_SHIFT >= SAMPLE_W) begin : g_bad_shift
        $error("FILT_SHIFT out of range");
    end

    cap_state_t                     state, state_nx;
    logic [CH_SEL_W-1:0]            cur_nx;
    logic [7:0]                     settle_cnt, settle_nx;
    logic [15:0]                    to_cnt, to_nx;
    logic                           store, to_pulse, advance;
    logic [15:0]                    en16;
    logic [CH_SEL_W-1:0]            nxt_ch, first_ch;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] val;
    logic [SAMPLE_W-1:0]            cur_val, new_val, rd_mux;

    assign en16     = 16'(ch_en);
    assign nxt_ch   = next_enabled(en16, channel, NUM_CH);
    assign first_ch = next_enabled(en16, CH_SEL_W'(NUM_CH - 1), NUM_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            channel    <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            state      <= state_nx;
            channel    <= cur_nx;
            settle_cnt <= settle_nx;
            to_cnt     <= to_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cur_nx    = channel;
        settle_nx = settle_cnt;
        to_nx     = to_cnt;
        store     = 1'b0;
        to_pulse  = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (en16 != '0) begin
                    cur_nx    = first_ch;
                    settle_nx = 8'(SETTLE_CYC);
                    state_nx  = SETTLE;
                end
            end
            SETTLE: begin
                if (!en16[channel]) begin
                    advance = 1'b1;
                end else if (settle_cnt <= 8'd1) begin
                    state_nx = WAIT;
                    to_nx    = 16'(TIMEOUT_CYC);
                end else begin
                    settle_nx = settle_cnt - 8'd1;
                end
            end
            WAIT: begin
                // Disable beats accept, accept beats an expiring timeout.
                if (!en16[channel]) begin
                    advance = 1'b1;
                end else if (new_sample && sample_channel == channel) begin
                    store   = 1'b1;
                    advance = 1'b1;
                end else if (to_cnt <= 16'd1) begin
                    to_pulse = 1'b1;
                    advance  = 1'b1;
                end else begin
                    to_nx = to_cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (advance) begin
            if (en16 == '0) begin
                state_nx = IDLE;
            end else if (nxt_ch == channel) begin
                state_nx = WAIT;
                to_nx    = 16'(TIMEOUT_CYC);
            end else begin
                cur_nx    = nxt_ch;
                state_nx  = SETTLE;
                settle_nx = 8'(SETTLE_CYC);
            end
        end
    end

    always_comb begin
        cur_val = '0;
        rd_mux  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (channel == CH_SEL_W'(i)) cur_val = val[i];
            if (rd_sel == CH_SEL_W'(i))  rd_mux  = val[i];
        end
    end

`ifdef MULTI_CAPTURE_FILTER_EN
    logic [15:0]                vld16;
    logic signed [SAMPLE_W:0]   diff, step, sum;

    assign vld16 = 16'(ch_valid);

    always_comb begin
        diff = $signed({1'b0, sample}) - $signed({1'b0, cur_val});
        step = diff >>> FILT_SHIFT;
        sum  = $signed({1'b0, cur_val}) + step;
        // First capture seeds the filter so it does not ramp up from zero.
        new_val = vld16[channel] ? sum[SAMPLE_W-1:0] : sample;
    end
`else
    assign new_val = sample;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val      <= '0;
            ch_valid <= '0;
            timeout  <= 1'b0;
            rd_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (store && channel == CH_SEL_W'(i)) begin
                    val[i]      <= new_val;
                    ch_valid[i] <= 1'b1;
                end
            end
            timeout <= to_pulse;
            rd_data <= rd_mux;
        end
    end

    multi_capture_pwm #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .values (val),
        .pwm    (pwm)
    );

endmodule

// File: tb/tb_multi_input_capture.sv
// Directed bench for multi_input_capture (NUM_CH=8, SAMPLE_W=10, SETTLE_CYC=4, TIMEOUT_CYC=16).
module tb_multi_input_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ch_en = '0;
    logic [3:0]  channel;
    logic        new_sample = 1'b0;
    logic [9:0]  sample = '0;
    logic [3:0]  sample_channel = '0;
    logic [7:0]  pwm;
    logic [7:0]  ch_valid;
    logic        timeout;
    logic [3:0]  rd_sel = '0;
    logic [9:0]  rd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_input_capture #(
        .NUM_CH      (8),
        .SAMPLE_W    (10),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (16),
        .FILT_SHIFT  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_en          (ch_en),
        .channel        (channel),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .pwm            (pwm),
        .ch_valid       (ch_valid),
        .timeout        (timeout),
        .rd_sel         (rd_sel),
        .rd_data        (rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    // Present one strobe across the next clock edge.
    task automatic strobe(input logic [9:0] s, input logic [3:0] ch);
        new_sample     = 1'b1;
        sample         = s;
        sample_channel = ch;
        tick();
        new_sample     = 1'b0;
    endtask

    task automatic count_pwm3(input string tag, input int exp);
        int high;
        high = 0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (pwm[3]) high++;
        end
        check(tag, high, exp);
    endtask

    initial begin
        int n_pulse;
        int pulse_t [3];
        int pulse_ch [3];
        int to_seen;

        // Reset and idle with nothing enabled.
        do_reset();
        tick();
        check("reset_channel", channel, 0);
        check("reset_pwm", pwm, 0);
        check("reset_valid", ch_valid, 0);
        check("reset_timeout", timeout, 0);
        check("reset_rd_data", rd_data, 0);
        ticks(1000);
        check("idle_channel", channel, 0);
        check("idle_pwm", pwm, 0);
        check("idle_valid", ch_valid, 0);
        check("idle_timeout", timeout, 0);

        // Settle discard on channels 0 and 2.
        ch_en  = 8'b0000_0101;
        rd_sel = 4'd0;
        tick();
        check("settle_channel0", channel, 0);
        strobe(10'd300, 4'd0);
        ticks(2);
        check("settle_discard_rd", rd_data, 0);
        check("settle_discard_valid", ch_valid, 0);
        tick();
        strobe(10'd500, 4'd0);
        check("accept_channel2", channel, 2);
        check("accept_valid", ch_valid, 8'h01);
        tick();
        check("accept_rd_data", rd_data, 500);

        // Timeout alternation on channels 0 and 1, no samples.
        do_reset();
        ch_en = 8'b0000_0011;
        tick();
        n_pulse = 0;
        to_seen = 0;
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (timeout) begin
                to_seen++;
                if (n_pulse < 3) begin
                    pulse_t[n_pulse]  = t;
                    pulse_ch[n_pulse] = int'(channel);
                    n_pulse++;
                end
            end
        end
        check("timeout_count", to_seen, 3);
        check("timeout_t0", pulse_t[0], 20);
        check("timeout_t1", pulse_t[1], 40);
        check("timeout_t2", pulse_t[2], 60);
        check("timeout_ch0", pulse_ch[0], 1);
        check("timeout_ch1", pulse_ch[1], 0);
        check("timeout_ch2", pulse_ch[2], 1);
        check("timeout_valid", ch_valid, 0);

        // Disable the current channel mid-WAIT with a matching strobe present.
        do_reset();
        ch_en  = 8'b0000_0011;
        rd_sel = 4'd0;
        tick();
        ticks(6);
        ch_en = 8'b0000_0010;
        strobe(10'd77, 4'd0);
        check("abandon_channel", channel, 1);
        check("abandon_timeout", timeout, 0);
        check("abandon_valid", ch_valid, 0);
        tick();
        check("abandon_rd_data", rd_data, 0);
        to_seen = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (timeout) to_seen++;
        end
        check("abandon_no_timeout", to_seen, 0);

        // PWM duty on channel 3 alone.
        do_reset();
        ch_en  = 8'b0000_1000;
        rd_sel = 4'd3;
        tick();
        check("pwm_channel3", channel, 3);
        ticks(4);
        strobe(10'd256, 4'd3);
        tick();
        count_pwm3("pwm_duty_256", 256);
        check("pwm_other_low", pwm & 8'hF7, 0);
        strobe(10'd7, 4'd2);
        tick();
        check("mismatch_rd_data", rd_data, 256);
        check("mismatch_valid", ch_valid, 8'h08);
        rd_sel = 4'd9;
        tick();
        check("rd_sel_oor", rd_data, 0);
        rd_sel = 4'd3;
        strobe(10'd0, 4'd3);
        tick();
        count_pwm3("pwm_duty_0", 0);
        strobe(10'd1023, 4'd3);
        tick();
        count_pwm3("pwm_duty_1023", 1023);
        check("pre_reset_rd_data", rd_data, 1023);

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_channel", channel, 0);
        check("async_valid", ch_valid, 0);
        check("async_pwm", pwm, 0);
        check("async_timeout", timeout, 0);
        check("async_rd_data", rd_data, 0);

        // Stored-value update sequence on channel 0.
        ch_en  = 8'b0000_0001;
        rd_sel = 4'd0;
        #2;
        rst_n = 1'b1;
        tick();
        ticks(4);
        strobe(10'd400, 4'd0);
        tick();
        check("store_first", rd_data, 400);
        strobe(10'd800, 4'd0);
        tick();
`ifdef MULTI_CAPTURE_FILTER_EN
        check("store_second", rd_data, 500);
`else
        check("store_second", rd_data, 800);
`endif
        strobe(10'd0, 4'd0);
        tick();
`ifdef MULTI_CAPTURE_FILTER_EN
        check("store_third", rd_data, 375);
`else
        check("store_third", rd_data, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
